gsim_stream_loader: RTL and testbench

//  Upstream/downstream front-end for the Gauss-Seidel solver (run_gsim).
//  - Accepts A (16x16) and b (16) as a stream of 16-bit words.
//  - Packs them onto the solver's wide buses and pulses a run via o_module_en.
//  - Waits for a fresh done, then serialises the 16 x-results (32-bit S15.16) on an output stream.

---
 rtl/gsim_stream_loader_pkg.sv | 18 +
 rtl/gsim_stream_loader_if.sv | 15 +
 rtl/gsim_stream_loader_out_ser.sv | 36 +++
 rtl/gsim_stream_loader.sv | 104 ++++++++++
 tb/tb_gsim_stream_loader.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gsim_stream_loader_pkg.sv
// gsim_stream_loader_pkg: shared sizes, FSM states and bus-offset helpers for the solver stream loader
package gsim_stream_loader_pkg;
   localparam int N_DIM   = 16;
   localparam int IN_W    = 16;
   localparam int X_W     = 32;
   localparam int N_WORDS = N_DIM * N_DIM + N_DIM;
   typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN} state_t;
   // A(r,c) arrives row-major as k = r*16+c but lives column-major on the bus at c*256 + r*16
   function automatic logic [11:0] a_off(input logic [7:0] k);
      return {k[3:0], k[7:4], 4'b0};
   endfunction
   function automatic logic [7:0] b_off(input logic [3:0] i);
      return {i, 4'b0};
   endfunction
   function automatic logic is_diag(input logic [8:0] k);
      return ~k[8] & (k[7:4] == k[3:0]);
   endfunction
endpackage

// File: rtl/gsim_stream_loader_if.sv
// gsim_stream_loader_if: input word stream and result stream handshakes of the loader
//   in_valid/in_data/in_ready    : 16-bit A/b words towards the loader
//   out_valid/out_data/out_ready : 32-bit x results away from the loader
//   master = environment side, slave = loader side
interface gsim_stream_loader_if;
   import gsim_stream_loader_pkg::*;
   logic            in_valid;
   logic [IN_W-1:0] in_data;
   logic            in_ready;
   logic            out_valid;
   logic [X_W-1:0]  out_data;
   logic            out_ready;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
   modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/gsim_stream_loader_out_ser.sv
// gsim_stream_loader_out_ser: serialises the 16 solver results onto a valid/ready stream
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_start        : begin a 16-beat drain
//   i_x            : packed results, x[r] at r*32
//   i_ready        : downstream accepts the current beat
//   o_valid/o_data : current beat, x[idx]; data forced to 0 when idle
//   o_last         : the beat carrying x[15] is accepted this cycle
module gsim_stream_loader_out_ser
   import gsim_stream_loader_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [N_DIM*X_W-1:0] i_x,
   input  logic               i_ready,
   output logic               o_valid,
   output logic [X_W-1:0]     o_data,
   output logic               o_last
);
   logic       r_valid;
   logic [3:0] r_idx;
   logic       w_beat;
   assign w_beat  = r_valid & i_ready;
   assign o_last  = w_beat & (r_idx == 4'd15);
   assign o_valid = r_valid;
   assign o_data  = r_valid ? i_x[r_idx*X_W +: X_W] : '0;
   // idx wraps 15 -> 0 on its own, leaving it ready for the next drain
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         r_valid <= 1'b0;
         r_idx   <= '0;
      end else begin
         r_valid <= i_start | (r_valid & ~o_last);
         r_idx   <= w_beat ? r_idx + 4'd1 : r_idx;
      end
endmodule

// File: rtl/gsim_stream_loader.sv
// gsim_stream_loader: streams A/b into the Gauss-Seidel solver, runs it and streams x back out
//   i_clk, i_reset : clock, asynchronous active-high reset
//   io_strm        : input word stream (272 words: A row-major, then b) and result stream
//   o_a, o_b       : packed matrix (column-major) and vector for the solver
//   o_module_en    : high for the whole run phase
//   i_done, i_x    : solver completion level and results
//   o_busy         : high outside the load phase
//   o_err          : zero-diagonal flag, only with GSIM_LDR_DIAG_CHECK_EN defined (else 0)
// Option macro: GSIM_LDR_DIAG_CHECK_EN - a zero diagonal skips the run and drains 16 zero words with o_err set
module gsim_stream_loader
   import gsim_stream_loader_pkg::*;
(
   input  logic                      i_clk,
   input  logic                      i_reset,
   gsim_stream_loader_if.slave       io_strm,
   output logic [N_DIM*N_DIM*IN_W-1:0] o_a,
   output logic [N_DIM*IN_W-1:0]     o_b,
   output logic                      o_module_en,
   input  logic                      i_done,
   input  logic [N_DIM*X_W-1:0]      i_x,
   output logic                      o_busy,
   output logic                      o_err
);
   state_t                     r_state;
   logic [8:0]                 r_cnt;
   logic [N_DIM*N_DIM*IN_W-1:0] r_a;
   logic [N_DIM*IN_W-1:0]      r_b;
   logic                       r_en, r_ready, r_busy, r_err, r_done_d;
   logic                       w_xfer, w_load_end, w_rise, w_start, w_last, w_diag_skip;
   assign w_xfer      = io_strm.in_valid & r_ready;
   assign w_load_end  = w_xfer & (r_cnt == 9'(N_WORDS - 1));
   // only a fresh 0->1 edge ends a run, so a done still high from the last run is ignored
   assign w_rise      = (r_state == S_RUN) & i_done & ~r_done_d;
   assign w_start     = w_rise | (w_load_end & w_diag_skip);
   assign io_strm.in_ready = r_ready;
   assign o_a         = r_a;
   assign o_b         = r_b;
   assign o_module_en = r_en;
   assign o_busy      = r_busy;
   assign o_err       = r_err;
`ifdef GSIM_LDR_DIAG_CHECK_EN
   logic r_diag;
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) r_diag <= 1'b0;
      else if (w_last) r_diag <= 1'b0;
      else if (w_xfer && is_diag(r_cnt) && io_strm.in_data == '0) r_diag <= 1'b1;
   assign w_diag_skip = r_diag;
`else
   assign w_diag_skip = 1'b0;
`endif
   gsim_stream_loader_out_ser u_ser (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_start (w_start),
      .i_x     (r_err ? '0 : i_x),
      .i_ready (io_strm.out_ready),
      .o_valid (io_strm.out_valid),
      .o_data  (io_strm.out_data),
      .o_last  (w_last)
   );
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         r_state  <= S_LOAD;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_en     <= 1'b0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
         r_done_d <= 1'b0;
      end else begin
         r_done_d <= i_done;
         case (r_state)
            S_LOAD: begin
               r_ready <= ~w_load_end;
               if (w_xfer) begin
                  if (r_cnt[8]) r_b[b_off(r_cnt[3:0]) +: IN_W] <= io_strm.in_data;
                  else r_a[a_off(r_cnt[7:0]) +: IN_W] <= io_strm.in_data;
                  r_cnt <= w_load_end ? '0 : r_cnt + 9'd1;
               end
               if (w_load_end) begin
                  r_state <= w_diag_skip ? S_DRAIN : S_RUN;
                  r_en    <= ~w_diag_skip;
                  r_err   <= w_diag_skip;
                  r_busy  <= 1'b1;
               end
            end
            S_RUN:
               if (w_rise) begin
                  r_state <= S_DRAIN;
                  r_en    <= 1'b0;
               end
            S_DRAIN:
               if (w_last) begin
                  r_state <= S_LOAD;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b0;
               end
            default: r_state <= S_LOAD;
         endcase
      end
endmodule

// File: tb/tb_gsim_stream_loader.sv
// tb_gsim_stream_loader: randomized self-checking bench with a behavioural packing/solver model
module tb_gsim_stream_loader;
   import gsim_stream_loader_pkg::*;
   logic          clk = 1'b0, rst = 1'b0, done = 1'b0;
   logic [511:0]  x_bus = '0;
   logic [4095:0] o_a;
   logic [255:0]  o_b;
   logic          en, busy, err;
   int            n_chk = 0, n_pass = 0;
   logic [15:0]   wq [272];
   logic [31:0]   xm [16];
   gsim_stream_loader_if io();
   gsim_stream_loader dut (
      .i_clk(clk), .i_reset(rst), .io_strm(io), .o_a(o_a), .o_b(o_b), .o_module_en(en),
      .i_done(done), .i_x(x_bus), .o_busy(busy), .o_err(err)
   );
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4095:0] ref_a();
      logic [4095:0] v = '0;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) v[c*256 + r*16 +: 16] = wq[r*16 + c];
      return v;
   endfunction

   function automatic logic [255:0] ref_b();
      logic [255:0] v = '0;
      for (int i = 0; i < 16; i++) v[i*16 +: 16] = wq[256 + i];
      return v;
   endfunction

   task automatic rand_words();
      for (int k = 0; k < 272; k++) wq[k] = 16'($urandom);
   endtask

   task automatic set_x();
      for (int i = 0; i < 16; i++) begin
         xm[i] = $urandom;
         x_bus[i*32 +: 32] = xm[i];
      end
   endtask

   task automatic load(input int stop_at, input bit bubbles, output int acc, output bit en_seen);
      bit hold = 0;
      int cyc = 0;
      acc = 0;
      en_seen = 0;
      while (acc < stop_at && cyc < 3000) begin
         if (!hold) io.in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
         io.in_data = io.in_valid ? wq[acc] : 16'($urandom);
         hold = io.in_valid && !io.in_ready;
         if (en) en_seen = 1;
         if (io.in_valid && io.in_ready) acc++;
         tick();
         cyc++;
      end
      io.in_valid = 1'b0;
   endtask

   task automatic run_to_drain(input int pre_high, input int total, output int viol);
      viol = 0;
      set_x();
      for (int i = 0; i < total; i++) begin
         done = (i < pre_high);
         if (io.out_valid || !en || io.in_ready) viol++;
         tick();
      end
      done = 1'b1;
      tick();
   endtask

   task automatic drain(input bit toggle, output int nb, output logic [31:0] got [16],
                        output int bad_stall, output int err_cyc);
      int cyc = 0, ph = 0;
      logic [31:0] prev = '0;
      bit stalled = 0;
      nb = 0;
      bad_stall = 0;
      err_cyc = 0;
      for (int i = 0; i < 16; i++) got[i] = 'x;
      while (nb < 16 && cyc < 400) begin
         io.out_ready = toggle ? (ph % 4 == 0 || ph % 4 == 3) : 1'b1;
         ph++;
         if (stalled && io.out_data !== prev) bad_stall++;
         if (io.out_valid && (err || en || io.in_ready)) err_cyc++;
         if (io.out_valid && io.out_ready) begin
            got[nb] = io.out_data;
            nb++;
         end
         stalled = io.out_valid && !io.out_ready;
         prev = io.out_data;
         tick();
         cyc++;
      end
      io.out_ready = 1'b0;
   endtask

   task automatic check_drain(input string name, input int nb, input logic [31:0] got [16]);
      int bad = 0;
      for (int i = 0; i < 16; i++) if (got[i] !== xm[i]) bad++;
      n_chk++;
      if (nb != 16 || bad != 0) $display("FAIL %s beats: got %0d beats with %0d wrong, required 16 beats matching x[0..15]", name, nb, bad);
      else n_pass++;
      n_chk++;
      if (io.out_valid !== 1'b0 || busy !== 1'b0 || io.in_ready !== 1'b1)
         $display("FAIL %s end: valid=%b busy=%b ready=%b, required 0 0 1", name, io.out_valid, busy, io.in_ready);
      else n_pass++;
   endtask

   task automatic test_reset();
      set_x();
      io.in_valid = 1'b1;
      io.in_data = 16'h1234;
      #2 rst = 1'b1;
      tick(); tick();
      n_chk++;
      if (o_a !== '0 || o_b !== '0) $display("FAIL reset_bus: o_a/o_b nonzero, required 0");
      else n_pass++;
      n_chk++;
      if ({en, io.in_ready, busy, io.out_valid, err} !== 5'b0 || io.out_data !== 32'h0)
         $display("FAIL reset_ctl: en/rdy/busy/vld/err=%b data=%h, required 0", {en, io.in_ready, busy, io.out_valid, err}, io.out_data);
      else n_pass++;
      io.in_valid = 1'b0;
      io.out_ready = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_identity();
      int acc, viol, nb, bs, ec, bad = 0;
      bit en_seen;
      logic [31:0] got [16];
      for (int k = 0; k < 256; k++) wq[k] = (k / 16 == k % 16) ? 16'h4000 : 16'h0000;
      for (int i = 0; i < 16; i++) wq[256 + i] = 16'(i + 1);
      load(272, 0, acc, en_seen);
      n_chk++;
      if (acc != 272 || en_seen) $display("FAIL ident_load: accepted %0d en_early=%b, required 272 0", acc, en_seen);
      else n_pass++;
      n_chk++;
      if (en !== 1'b1 || busy !== 1'b1 || io.in_ready !== 1'b0)
         $display("FAIL ident_en: en=%b busy=%b ready=%b, required 1 1 0", en, busy, io.in_ready);
      else n_pass++;
      for (int c = 0; c < 16; c++) if (o_a[c*256 + c*16 +: 16] !== 16'h4000) bad++;
      n_chk++;
      if (bad != 0) $display("FAIL ident_diag: %0d diagonal slots wrong, required 0", bad);
      else n_pass++;
      n_chk++;
      if (o_a !== ref_a() || o_b !== ref_b()) $display("FAIL ident_pack: o_b=%h, required %h", o_b, ref_b());
      else n_pass++;
      run_to_drain(0, 20, viol);
      n_chk++;
      if (viol != 0 || io.out_valid !== 1'b1 || en !== 1'b0)
         $display("FAIL ident_run: viol=%0d valid=%b en=%b, required 0 1 0", viol, io.out_valid, en);
      else n_pass++;
      drain(0, nb, got, bs, ec);
      check_drain("ident", nb, got);
   endtask

   task automatic test_done_edge();
      int acc, viol, nb, bs, ec;
      bit en_seen;
      logic [31:0] got [16];
      rand_words();
      done = 1'b1;
      load(272, 0, acc, en_seen);
      run_to_drain(10, 300, viol);
      n_chk++;
      if (acc != 272 || viol != 0) $display("FAIL done_level: accepted %0d early-exit cycles %0d, required 272 0", acc, viol);
      else n_pass++;
      n_chk++;
      if (io.out_valid !== 1'b1 || en !== 1'b0) $display("FAIL done_edge: valid=%b en=%b, required 1 0", io.out_valid, en);
      else n_pass++;
      drain(0, nb, got, bs, ec);
      check_drain("done_edge", nb, got);
   endtask

   task automatic test_drain_stall();
      int acc, viol, nb, bs, ec;
      bit en_seen;
      logic [31:0] got [16];
      int held = 0;
      rand_words();
      load(272, 0, acc, en_seen);
      run_to_drain(0, 8, viol);
      io.out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (io.out_valid === 1'b1 && io.out_data === xm[0]) held++;
         tick();
      end
      n_chk++;
      if (held != 20) $display("FAIL stall_hold: held %0d of 20 cycles, required 20", held);
      else n_pass++;
      drain(1, nb, got, bs, ec);
      n_chk++;
      if (bs != 0 || ec != 0) $display("FAIL stall_stable: changed-while-stalled %0d bad-ctl %0d, required 0 0", bs, ec);
      else n_pass++;
      check_drain("stall", nb, got);
   endtask

   task automatic test_random_bubbles();
      int acc, viol, nb, bs, ec;
      bit en_seen;
      logic [31:0] got [16];
      rand_words();
      load(272, 1, acc, en_seen);
      n_chk++;
      if (acc != 272 || o_a !== ref_a() || o_b !== ref_b()) $display("FAIL bubble_pack: accepted %0d or packing wrong, required 272 and model packing", acc);
      else n_pass++;
      io.in_valid = 1'b1;
      io.in_data = 16'hdead;
      run_to_drain(0, 30, viol);
      n_chk++;
      if (viol != 0) $display("FAIL bubble_run_ready: %0d bad cycles, required 0", viol);
      else n_pass++;
      drain(0, nb, got, bs, ec);
      io.in_valid = 1'b0;
      n_chk++;
      if (ec != 0 || o_a !== ref_a() || o_b !== ref_b()) $display("FAIL bubble_corrupt: bad-ctl %0d or bus changed, required 0 and unchanged", ec);
      else n_pass++;
      check_drain("bubble", nb, got);
   endtask

   task automatic test_reset_mid();
      int acc, viol, nb, bs, ec;
      bit en_seen;
      logic [31:0] got [16];
      rand_words();
      load(100, 0, acc, en_seen);
      rst = 1'b1;
      #1;
      n_chk++;
      if (acc != 100 || o_a !== '0 || o_b !== '0 || {en, busy, io.in_ready, io.out_valid} !== 4'b0)
         $display("FAIL midrst: accepted %0d, ctl=%b, required 100 and all zero", acc, {en, busy, io.in_ready, io.out_valid});
      else n_pass++;
      tick();
      rst = 1'b0;
      rand_words();
      load(272, 1, acc, en_seen);
      n_chk++;
      if (acc != 272 || en !== 1'b1 || o_a !== ref_a() || o_b !== ref_b())
         $display("FAIL midrst_reload: accepted %0d en=%b or packing wrong, required 272 1", acc, en);
      else n_pass++;
      run_to_drain(0, 5, viol);
      drain(0, nb, got, bs, ec);
      check_drain("midrst", nb, got);
   endtask

   task automatic test_diag();
      int acc, viol, nb, bs, ec, bad = 0;
      bit en_seen;
      logic [31:0] got [16];
      rand_words();
      for (int r = 0; r < 16; r++) wq[r*17] = wq[r*17] | 16'h0001;
      wq[5*17] = 16'h0000;
      load(272, 0, acc, en_seen);
`ifdef GSIM_LDR_DIAG_CHECK_EN
      n_chk++;
      if (acc != 272 || en_seen || en !== 1'b0 || io.out_valid !== 1'b1 || err !== 1'b1)
         $display("FAIL diag_skip: acc=%0d en=%b valid=%b err=%b, required 272 0 1 1", acc, en, io.out_valid, err);
      else n_pass++;
      drain(0, nb, got, bs, ec);
      for (int i = 0; i < 16; i++) if (got[i] !== 32'h0) bad++;
      n_chk++;
      if (nb != 16 || bad != 0 || ec != 16) $display("FAIL diag_drain: beats %0d nonzero %0d err-cycles %0d, required 16 0 16", nb, bad, ec);
      else n_pass++;
      n_chk++;
      if (err !== 1'b0 || busy !== 1'b0 || en !== 1'b0) $display("FAIL diag_after: err=%b busy=%b en=%b, required 0 0 0", err, busy, en);
      else n_pass++;
`else
      n_chk++;
      if (acc != 272 || en !== 1'b1 || err !== 1'b0) $display("FAIL nodiag_run: acc=%0d en=%b err=%b, required 272 1 0", acc, en, err);
      else n_pass++;
      run_to_drain(0, 5, viol);
      drain(0, nb, got, bs, ec);
      n_chk++;
      if (ec != 0 || bad != 0) $display("FAIL nodiag_err: bad-ctl cycles %0d, required 0", ec);
      else n_pass++;
      check_drain("nodiag", nb, got);
`endif
   endtask

   initial begin
      io.in_valid = 1'b0;
      io.in_data = '0;
      io.out_ready = 1'b0;
      test_reset();
      test_identity();
      test_done_edge();
      test_drain_stall();
      test_random_bubbles();
      test_reset_mid();
      test_diag();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
